// File: rtl/reaction_bot_player.sv
// Automated responder for the reaction-time game: sees the go LED rise, waits a programmable
// number of ticks, then holds the button. Define BOT_BOUNCE_EN to add contact bounce at press start.
module reaction_bot_player #(
    parameter int TICK_DIV   = 1000,
    parameter int HOLD_TICKS = 20,
    parameter int DLY_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             go_led_i,
    input  logic [DLY_W-1:0] delay_ticks_i,
    output logic             press_o,
    output logic             busy_o,
    output logic             missed_o,
    output logic [7:0]       press_count_o
);

`ifdef BOT_BOUNCE_EN
    localparam int PRESS_TICKS = HOLD_TICKS + 4;
`else
    localparam int PRESS_TICKS = HOLD_TICKS;
`endif
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW    = $clog2(PRESS_TICKS) + 1;
    localparam int TW    = (DLY_W > HW) ? DLY_W : HW;

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PRESS, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s2d_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              press_q, press_d;
    logic              busy_q, busy_d;
    logic              missed_q, missed_d;
    logic [7:0]        cnt_q, cnt_d;

    logic rise, fall, tick_end, dly_done, hold_done, press_phase;

    assign rise      = s2_q & ~s2d_q;
    assign fall      = ~s2_q & s2d_q;
    assign tick_end  = (presc_q == PW'(TICK_DIV - 1));
    assign dly_done  = tick_end && ((tick_q + TW'(1)) == TW'(dly_q));
    assign hold_done = tick_end && (tick_q == TW'(PRESS_TICKS - 1));

`ifdef BOT_BOUNCE_EN
    // First four ticks of the press alternate 1,0,1,0 to mimic a bouncing contact.
    assign press_phase = (tick_q >= TW'(4)) || !tick_q[0];
`else
    assign press_phase = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick_d   = tick_q;
        dly_d    = dly_q;
        missed_d = 1'b0;
        cnt_d    = cnt_q;

        // Shared tick prescaler; the states that do not time simply clear it below.
        if (tick_end) begin
            presc_d = '0;
            tick_d  = tick_q + TW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                presc_d = '0;
                tick_d  = '0;
                state_d = ARMED;
            end
            ARMED: begin
                presc_d = '0;
                tick_d  = '0;
                if (rise) begin
                    dly_d   = delay_ticks_i;
                    state_d = (delay_ticks_i == '0) ? PRESS : DELAY;
                end
            end
            DELAY: begin
                if (dly_done) begin
                    state_d = PRESS;
                    presc_d = '0;
                    tick_d  = '0;
                end else if (fall) begin
                    state_d  = ARMED;
                    missed_d = 1'b1;
                    presc_d  = '0;
                    tick_d   = '0;
                end
            end
            PRESS: begin
                if (hold_done) begin
                    state_d = RELEASE;
                    presc_d = '0;
                    tick_d  = '0;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                presc_d = '0;
                tick_d  = '0;
                if (!s2_q) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase

        if (!en_i) begin
            state_d  = IDLE;
            presc_d  = '0;
            tick_d   = '0;
            missed_d = 1'b0;
            cnt_d    = cnt_q;
        end
    end

    // press lags the PRESS state by one edge, giving the rise at N+3+D*TICK_DIV.
    assign press_d = en_i && (state_q == PRESS) && press_phase;
    assign busy_d  = (state_d == DELAY) || (state_d == PRESS) || (state_d == RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s2d_q    <= 1'b0;
            presc_q  <= '0;
            tick_q   <= '0;
            dly_q    <= '0;
            press_q  <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s1_q     <= go_led_i;
            s2_q     <= s1_q;
            s2d_q    <= s2_q;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            dly_q    <= dly_d;
            press_q  <= press_d;
            busy_q   <= busy_d;
            missed_q <= missed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o       = press_q;
    assign busy_o        = busy_q;
    assign missed_o      = missed_q;
    assign press_count_o = cnt_q;

endmodule

// File: tb/tb_reaction_bot_player.sv
// Randomized bench for reaction_bot_player: each go_led episode is predicted from the
// latency/duration rules relative to the first edge that samples the LED high.
module tb_reaction_bot_player;
    localparam int TD   = 4;
    localparam int HOLD = 2;
`ifdef BOT_BOUNCE_EN
    localparam int HP = HOLD + 4;
`else
    localparam int HP = HOLD;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       go = 1'b0;
    logic [7:0] dly = '0;
    logic       press, busy, missed;
    logic [7:0] cnt;

    int errs = 0;
    int checks = 0;
    int exp_cnt = 0;

    reaction_bot_player #(.TICK_DIV(TD), .HOLD_TICKS(HOLD), .DLY_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .go_led_i(go), .delay_ticks_i(dly),
        .press_o(press), .busy_o(busy), .missed_o(missed), .press_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One episode: go_led held high for l sampled edges, delay d ticks.
    task automatic run_scn(input int d, input int l);
        int  pstart, pend, busy_end, tot, ph;
        bit  miss, pe;
        miss     = (d > 0) && (l < d * TD);
        pstart   = 3 + d * TD;
        pend     = 2 + (d + HP) * TD;
        busy_end = miss ? l + 1 : ((pend > l + 1) ? pend : l + 1);
        tot      = ((l > pend) ? l : pend) + 6;
        dly      = 8'(d);
        for (int r = 0; r < tot; r++) begin
            go = (r < l);
            if (r == 3) dly = 8'($urandom);
            step();
            pe = !miss && (r >= pstart) && (r <= pend);
            ph = (r - pstart) / TD;
`ifdef BOT_BOUNCE_EN
            if (pe && ph < 4) pe = (ph % 2 == 0);
`endif
            chk("press", press, pe);
            chk("missed", missed, miss && (r == l + 2));
            chk("busy", busy, (r >= 2) && (r <= busy_end));
        end
        if (!miss && exp_cnt < 255) exp_cnt++;
        chk("count", cnt, exp_cnt);
    endtask

    initial begin
        int d, l;
        repeat (3) step();
        chk("rst_press", press, 0);
        chk("rst_busy", busy, 0);
        chk("rst_missed", missed, 0);
        chk("rst_count", cnt, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) step();

        run_scn(5, 40);
        run_scn(0, 5);
        run_scn(10, 12);
        run_scn(2, 8);
        run_scn(2, 7);

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 6));
            if (d > 0 && ($urandom % 3) == 0) l = int'($urandom_range(1, d * TD - 1));
            else l = int'($urandom_range((d * TD > 1) ? d * TD : 1, d * TD + HP * TD + 8));
            run_scn(d, l);
        end

        // Drop enable two cycles into a press.
        dly = 8'd1;
        for (int r = 0; r <= 9; r++) begin
            go = 1'b1;
            en = (r < 9);
            step();
            if (r == 8) chk("en_pre_press", press, 1);
        end
        chk("en_drop_press", press, 0);
        chk("en_drop_busy", busy, 0);
        go = 1'b0;
        repeat (4) step();
        chk("en_drop_count", cnt, exp_cnt);
        en = 1'b1;
        repeat (4) step();
        run_scn(1, 10);

        for (int i = 0; i < 260; i++) run_scn(0, 2);
        chk("sat_count", cnt, 255);

        // Asynchronous reset in the middle of a press.
        dly = 8'd0;
        for (int r = 0; r < 5; r++) begin
            go = 1'b1;
            step();
        end
        chk("pre_rst_press", press, 1);
        rst_n = 1'b0;
        #2;
        chk("async_press", press, 0);
        chk("async_busy", busy, 0);
        chk("async_count", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
